cp0_ctrl: RTL and testbench
===========================

Name: cp0_ctrl

Overview:
- Coprocessor-0 register file and exception sequencer for the 5-stage MIPS core.
- Consumes the prioritised exception code generated in the M stage.
- On a taken exception it updates EPC, Cause, Status and BadVAddr; on ERET it leaves exception level.
- Runs the Count/Compare timer and samples external interrupts into Cause.IP.
- Executes MTC0 writes and serves MFC0 reads.

Parameters:
- PRID, 32'h0000_4220, read-only value of PRId (reg 15)
- CONFIG, 32'h8000_0000, read-only value of Config (reg 16)

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- we_i  input  1  MTC0 write enable (M stage)
- waddr_i  input  5  MTC0 register number
- wdata_i  input  32  MTC0 write data
- raddr_i  input  5  MFC0 register number
- int_i  input  6  external hardware interrupt lines
- excepttype_i  input  32  exception code: 0 none, 1 INT, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, a RI, c Ov, e ERET
- pc_i  input  32  M-stage instruction address
- in_delayslot_i  input  1  M-stage instruction is in a branch delay slot
- bad_addr_i  input  32  faulting address for AdEL/AdES
- rdata_o  output  32  MFC0 read data
- status_o  output  32  Status register
- cause_o  output  32  Cause register
- epc_o  output  32  EPC register
- count_o  output  32  Count register
- compare_o  output  32  Compare register
- badvaddr_o  output  32  BadVAddr register
- timer_int_o  output  1  pending timer interrupt

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - Status = 32'h0040_0000 (BEV=1).
  - Cause, EPC, Count, Compare and BadVAddr = 0.
  - timer_int_o = 0; internal count-phase toggle = 0.
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
- rdata_o:
  - Combinational from current register state; no bypass of a same-cycle write.
  - Unmapped numbers read 0.
- Count:
  - The phase toggle inverts every cycle; Count increments when the toggle is 1, giving a 1/2 clock rate.
  - Wraps from 32'hFFFF_FFFF to 0.
- Timer interrupt:
  - timer_int_o sets (registered) when Compare != 0 and Count == Compare.
  - Stays set until an MTC0 write to Compare, which clears it in that same edge.
- Cause interrupt bits:
  - Cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]} every cycle.
  - This sampling is not suppressed by exceptions.
- MTC0 (we_i=1 and excepttype_i==0), writable fields only:
  - Count: all 32 bits; the phase toggle clears.
  - Compare: all 32 bits.
  - Status: bits 15:8, 1, 0.
  - Cause: bits 9:8.
  - EPC: all 32 bits.
  - BadVAddr, PRId and Config ignore writes.
- Exception-vs-MTC0 priority: when excepttype_i != 0, the MTC0 write is discarded (the instruction is flushed).
- Exception entry (excepttype_i in {1,4,5,8,9,a,c}):
  - If Status.EXL==0:
    - EPC <= in_delayslot_i ? pc_i-4 : pc_i.
    - Cause.BD (bit 31) <= in_delayslot_i.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2] <= 0 for code 1, otherwise excepttype_i[4:0].
  - BadVAddr <= bad_addr_i for codes 4 and 5 only.
- ERET (excepttype_i==e): Status.EXL <= 0; all other registers unchanged except the free-running Count and Cause.IP.
- Unlisted nonzero excepttype_i values: no register effect beyond MTC0 suppression.
- All updates take effect at the clock edge after the inputs are presented (1-cycle latency).
- Status.EXL is visible on status_o in the next cycle.

Test Plan:
- Reset: rst high mid-run → all outputs zero immediately except status_o=32'h0040_0000; rdata_o=32'h0000_4220 for raddr 15.
- Count/timer:
  - MTC0 Compare=5 → count_o reaches 5 after 10 cycles; timer_int_o=1 on the next edge; cause_o[15]=1 one cycle later.
  - MTC0 Compare=7 → timer_int_o=0.
- Syscall in delay slot: excepttype_i=8, pc_i=32'hBFC0_0104, in_delayslot_i=1, EXL=0 → epc_o=32'hBFC0_0100, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
- AdEL with same-cycle MTC0 EPC=32'h1234: excepttype_i=4, bad_addr_i=32'h8000_0003, pc_i=32'h8000_0010 → badvaddr_o=32'h8000_0003, epc_o=32'h8000_0010; MTC0 discarded.
- Nested exception: EXL=1, excepttype_i=a → epc_o unchanged, ExcCode=a; then excepttype_i=e → status_o[1]=0.
- MTC0 Status=32'hFFFF_FFFF → status_o=32'h0040_FF03; MTC0 Cause=32'hFFFF_FFFF → cause_o[9:8]=2'b11 and no other bits changed.

Source files
------------

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - coprocessor-0 register file and exception sequencer
module cp0_ctrl #(
  parameter logic [31:0] PRID   = 32'h0000_4220,
  parameter logic [31:0] CONFIG = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic phase;
  logic exc_take;
  logic exc_eret;
  logic exc_addr;
  logic mtc0;

  always_comb begin
    exc_take = 1'b0;
    exc_addr = 1'b0;
    case (excepttype_i)
      32'h1, 32'h8, 32'h9, 32'ha, 32'hc: exc_take = 1'b1;
      32'h4, 32'h5: begin
        exc_take = 1'b1;
        exc_addr = 1'b1;
      end
      default: ;
    endcase
  end

  assign exc_eret = (excepttype_i == 32'he);
  // Any nonzero code flushes the M-stage instruction, so its MTC0 is dropped.
  assign mtc0     = we_i && (excepttype_i == 32'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o <= 32'h0;
      phase   <= 1'b0;
    end else if (mtc0 && waddr_i == REG_COUNT) begin
      count_o <= wdata_i;
      phase   <= 1'b0;
    end else begin
      phase <= ~phase;
      if (phase) count_o <= count_o + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_o   <= 32'h0;
      timer_int_o <= 1'b0;
    end else if (mtc0 && waddr_i == REG_COMPARE) begin
      compare_o   <= wdata_i;
      timer_int_o <= 1'b0;
    end else if (compare_o != 32'h0 && count_o == compare_o) begin
      timer_int_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_o <= STATUS_RESET;
    end else if (exc_take) begin
      status_o[1] <= 1'b1;
    end else if (exc_eret) begin
      status_o[1] <= 1'b0;
    end else if (mtc0 && waddr_i == REG_STATUS) begin
      status_o <= (status_o & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
    end
  end

  // IP sampling runs every cycle regardless of exceptions; timer shares IP7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_o <= 32'h0;
    end else begin
      cause_o[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (exc_take) begin
        if (!status_o[1]) cause_o[31] <= in_delayslot_i;
        cause_o[6:2] <= (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];
      end else if (mtc0 && waddr_i == REG_CAUSE) begin
        cause_o[9:8] <= wdata_i[9:8];
      end
    end
  end

  // A nested exception keeps the EPC of the original fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_o <= 32'h0;
    end else if (exc_take) begin
      if (!status_o[1]) epc_o <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
    end else if (mtc0 && waddr_i == REG_EPC) begin
      epc_o <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr_o <= 32'h0;
    end else if (exc_addr) begin
      badvaddr_o <= bad_addr_i;
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_o;
      REG_COUNT:    rdata_o = count_o;
      REG_COMPARE:  rdata_o = compare_o;
      REG_STATUS:   rdata_o = status_o;
      REG_CAUSE:    rdata_o = cause_o;
      REG_EPC:      rdata_o = epc_o;
      REG_PRID:     rdata_o = PRID;
      REG_CONFIG:   rdata_o = CONFIG;
      default:      rdata_o = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - self-checking bench for cp0_ctrl
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = '0;
  logic [5:0]  int_v = '0;
  logic [31:0] etype = '0;
  logic [31:0] pc = '0;
  logic        ds = 1'b0;
  logic [31:0] badaddr = '0;
  logic [31:0] rdata, status, cause, epc, count, compare, badv;
  logic        timer;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_status, m_cause, m_epc, m_compare, m_badv, m_cbase;
  logic        m_timer;
  longint unsigned m_half;

  cp0_ctrl dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .int_i(int_v), .excepttype_i(etype), .pc_i(pc),
    .in_delayslot_i(ds), .bad_addr_i(badaddr), .rdata_o(rdata),
    .status_o(status), .cause_o(cause), .epc_o(epc), .count_o(count),
    .compare_o(compare), .badvaddr_o(badv), .timer_int_o(timer)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_half >> 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0000_4220;
      5'd16: return 32'h8000_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_compare = 0;
    m_badv = 0; m_cbase = 0; m_half = 0; m_timer = 0;
  endtask

  // Next architectural state from the values presented at this edge.
  task automatic m_edge();
    logic [31:0] cnt_now;
    logic        wr, exc, hit;
    logic [5:0]  ip;
    cnt_now = m_count();
    wr  = we && (etype == 32'h0);
    exc = etype inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
    ip  = {int_v[5] | m_timer, int_v[4:0]};
    hit = (m_compare != 0) && (cnt_now == m_compare);
    if (wr && waddr == 5'd9) begin m_cbase = wdata; m_half = 0; end
    else m_half = m_half + 1;
    if (wr && waddr == 5'd11) begin m_compare = wdata; m_timer = 1'b0; end
    else if (hit) m_timer = 1'b1;
    if (exc) begin
      if (m_status[1] == 1'b0) begin
        m_epc = ds ? pc - 32'd4 : pc;
        m_cause[31] = ds;
      end
      m_status[1] = 1'b1;
      m_cause[6:2] = (etype == 32'h1) ? 5'd0 : etype[4:0];
      if (etype == 32'h4 || etype == 32'h5) m_badv = badaddr;
    end else if (etype == 32'he) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      case (waddr)
        5'd12: begin m_status[15:8] = wdata[15:8]; m_status[1:0] = wdata[1:0]; end
        5'd13: m_cause[9:8] = wdata[9:8];
        5'd14: m_epc = wdata;
        default: ;
      endcase
    end
    m_cause[15:10] = ip;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("status", status, m_status);
    chk("cause", cause, m_cause);
    chk("epc", epc, m_epc);
    chk("count", count, m_count());
    chk("compare", compare, m_compare);
    chk("badvaddr", badv, m_badv);
    chk("timer", {31'h0, timer}, {31'h0, m_timer});
    chk("rdata", rdata, m_read(raddr));
  endtask

  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] et, input logic [31:0] p, input logic d,
                      input logic [31:0] ba, input logic [5:0] ii, input logic [4:0] ra);
    we = w; waddr = wa; wdata = wd; etype = et; pc = p; ds = d;
    badaddr = ba; int_v = ii; raddr = ra;
    @(posedge clk);
    m_edge();
    #1;
    chk_model();
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, ra);
  endtask

  logic [31:0] codes [13];
  logic [4:0]  regs [10];

  initial begin
    codes = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h4, 32'h5,
              32'h8, 32'h9, 32'ha, 32'hc, 32'he};
    regs  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3, 5'd0};
    m_reset();
    raddr = 5'd15;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_status", status, 32'h0040_0000);
    chk("rst_count", count, 32'h0);
    chk("rst_prid", rdata, 32'h0000_4220);
    chk_model();

    step(1'b1, 5'd11, 32'd5, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, 5'd11);
    idle(12, 5'd9);
    chk("timer_set", {31'h0, timer}, 32'h1);
    chk("cause_ip7", {31'h0, cause[15]}, 32'h1);
    step(1'b1, 5'd11, 32'd7, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, 5'd13);
    chk("timer_clr", {31'h0, timer}, 32'h0);

    step(1'b0, 5'd0, 32'h0, 32'h8, 32'hBFC0_0104, 1'b1, 32'h0, 6'h0, 5'd14);
    chk("sys_epc", epc, 32'hBFC0_0100);
    chk("sys_bd", {31'h0, cause[31]}, 32'h1);
    chk("sys_code", {27'h0, cause[6:2]}, 32'h8);
    chk("sys_exl", {31'h0, status[1]}, 32'h1);
    step(1'b0, 5'd0, 32'h0, 32'he, 32'h0, 1'b0, 32'h0, 6'h0, 5'd12);

    step(1'b1, 5'd14, 32'h1234, 32'h4, 32'h8000_0010, 1'b0, 32'h8000_0003, 6'h0, 5'd8);
    chk("adel_badv", badv, 32'h8000_0003);
    chk("adel_epc", epc, 32'h8000_0010);
    step(1'b0, 5'd0, 32'h0, 32'ha, 32'h9000_0000, 1'b1, 32'h0, 6'h15, 5'd13);
    chk("nest_epc", epc, 32'h8000_0010);
    chk("nest_code", {27'h0, cause[6:2]}, 32'ha);
    step(1'b0, 5'd0, 32'h0, 32'he, 32'h0, 1'b0, 32'h0, 6'h0, 5'd12);
    chk("eret_exl", {31'h0, status[1]}, 32'h0);

    step(1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, 5'd12);
    chk("mtc0_status", status, 32'h0040_FF03);
    step(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, 5'd13);
    chk("mtc0_cause98", {30'h0, cause[9:8]}, 32'h3);
    step(1'b1, 5'd15, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, 5'd15);
    step(1'b1, 5'd9, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, 5'd9);
    idle(4, 5'd9);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] wd;
      logic [4:0]  wa;
      wa = regs[$urandom_range(0, 9)];
      wd = $urandom;
      if (wa == 5'd11 && $urandom_range(0, 1) == 0) wd = m_count() + 32'($urandom_range(0, 6));
      step($urandom_range(0, 2) == 0, wa, wd, codes[$urandom_range(0, 12)],
           $urandom, $urandom_range(0, 1) == 1, $urandom, 6'($urandom),
           regs[$urandom_range(0, 9)]);
    end

    @(negedge clk);
    #2;
    raddr = 5'd15;
    rst = 1'b1;
    #1;
    chk("arst_status", status, 32'h0040_0000);
    chk("arst_cause", cause, 32'h0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_count", count, 32'h0);
    chk("arst_compare", compare, 32'h0);
    chk("arst_badv", badv, 32'h0);
    chk("arst_timer", {31'h0, timer}, 32'h0);
    chk("arst_prid", rdata, 32'h0000_4220);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(5, 5'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
